// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto one strobed memory.
// Build option: define ARB_ROUND_ROBIN_EN for an alternating tie-break; otherwise data wins ties.
module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       f_req,
  input  logic [7:0] f_addr,
  output logic       f_ack,
  output logic [7:0] f_rdata,
  input  logic       d_req,
  input  logic       d_we,
  input  logic [7:0] d_addr,
  input  logic [7:0] d_wdata,
  output logic       d_ack,
  output logic [7:0] d_rdata,
  output logic [7:0] address,
  output logic [7:0] to_mem,
  input  logic [7:0] from_mem,
  output logic       mem_clock,
  output logic       mem_write,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 32'd0) ? 4'd0 : 4'(WAIT_CYCLES - 32'd1);

  state_t     state_q;
  logic [3:0] wait_cnt_q;
  logic       sel_data_q;
  logic       f_ack_q, d_ack_q;
  logic [7:0] f_rdata_q, d_rdata_q;
  logic [7:0] address_q, to_mem_q;
  logic       mem_clock_q, mem_write_q, busy_q;
  logic       grant_d, sel_data_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic       last_data_q;
`endif

  // Grant decision: only from IDLE, and never while an ack from the previous transfer is visible.
  always_comb begin
    grant_d    = 1'b0;
    sel_data_d = 1'b0;
    if ((state_q == IDLE) && !f_ack_q && !d_ack_q && (f_req || d_req)) begin
      grant_d = 1'b1;
      if (f_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        sel_data_d = ~last_data_q;
`else
        sel_data_d = 1'b1;
`endif
      end else begin
        sel_data_d = d_req;
      end
    end else begin
      grant_d    = 1'b0;
      sel_data_d = 1'b0;
    end
  end

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= 4'd0;
      sel_data_q  <= 1'b0;
      f_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      f_rdata_q   <= 8'h00;
      d_rdata_q   <= 8'h00;
      address_q   <= 8'h00;
      to_mem_q    <= 8'h00;
      mem_clock_q <= 1'b0;
      mem_write_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_data_q <= 1'b1;
`endif
    end else begin
      f_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            state_q     <= STROBE;
            busy_q      <= 1'b1;
            mem_clock_q <= 1'b1;
            sel_data_q  <= sel_data_d;
            address_q   <= sel_data_d ? d_addr : f_addr;
            to_mem_q    <= sel_data_d ? d_wdata : to_mem_q;
            mem_write_q <= sel_data_d & d_we;
`ifdef ARB_ROUND_ROBIN_EN
            last_data_q <= sel_data_d;
`endif
          end
        end
        STROBE: begin
          mem_clock_q <= 1'b0;
          wait_cnt_q  <= WAIT_LOAD;
          if (WAIT_CYCLES == 32'd0) begin
            state_q <= DONE;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt_q == 4'd0) begin
            state_q <= DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
          end
        end
        DONE: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          mem_write_q <= 1'b0;
          // mem_write_q still holds the latched store flag at this point.
          if (sel_data_q) begin
            d_ack_q <= 1'b1;
            if (!mem_write_q) begin
              d_rdata_q <= from_mem;
            end
          end else begin
            f_ack_q   <= 1'b1;
            f_rdata_q <= from_mem;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign f_ack     = f_ack_q;
  assign d_ack     = d_ack_q;
  assign f_rdata   = f_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign address   = address_q;
  assign to_mem    = to_mem_q;
  assign mem_clock = mem_clock_q;
  assign mem_write = mem_write_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: a WAIT_CYCLES=1 instance and a WAIT_CYCLES=0 instance.
module tb_mem_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       f_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [7:0] f_addr = 8'h00, d_addr = 8'h00, d_wdata = 8'h00;
  logic       f_ack, d_ack, mem_clock, mem_write, busy;
  logic [7:0] f_rdata, d_rdata, address, to_mem;
  logic [7:0] from_mem;

  logic       z_f_req = 1'b0, z_d_req = 1'b0, z_d_we = 1'b0;
  logic [7:0] z_f_addr = 8'h00, z_d_addr = 8'h00, z_d_wdata = 8'h00;
  logic       z_f_ack, z_d_ack, z_mem_clock, z_mem_write, z_busy;
  logic [7:0] z_f_rdata, z_d_rdata, z_address, z_to_mem;
  logic [7:0] z_from_mem;

  logic [7:0] mem   [0:255];
  logic [7:0] z_mem [0:255];

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  mem_arbiter #(.WAIT_CYCLES(1)) dut (
    .clock(clock), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .address(address), .to_mem(to_mem), .from_mem(from_mem),
    .mem_clock(mem_clock), .mem_write(mem_write), .busy(busy)
  );

  mem_arbiter #(.WAIT_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset),
    .f_req(z_f_req), .f_addr(z_f_addr), .f_ack(z_f_ack), .f_rdata(z_f_rdata),
    .d_req(z_d_req), .d_we(z_d_we), .d_addr(z_d_addr), .d_wdata(z_d_wdata),
    .d_ack(z_d_ack), .d_rdata(z_d_rdata),
    .address(z_address), .to_mem(z_to_mem), .from_mem(z_from_mem),
    .mem_clock(z_mem_clock), .mem_write(z_mem_write), .busy(z_busy)
  );

  // Memory model: acts on the rising edge of the strobe.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hA5;
    from_mem = 8'h00;
    forever begin
      @(posedge mem_clock);
      #1;
      if (mem_write) mem[address] = to_mem;
      else from_mem = mem[address];
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) z_mem[i] = 8'h00;
    z_mem[8'h30] = 8'h7E;
    z_mem[8'h31] = 8'h11;
    z_from_mem = 8'h00;
    forever begin
      @(posedge z_mem_clock);
      #1;
      if (z_mem_write) z_mem[z_address] = z_to_mem;
      else z_from_mem = z_mem[z_address];
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %h want 0", busy); end
    checks++; if (mem_clock !== 1'b0) begin errors++; $display("FAIL rst_mem_clock got %h want 0", mem_clock); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL rst_mem_write got %h want 0", mem_write); end
    checks++; if (address !== 8'h00) begin errors++; $display("FAIL rst_address got %h want 00", address); end
    checks++; if (to_mem !== 8'h00) begin errors++; $display("FAIL rst_to_mem got %h want 00", to_mem); end
    checks++; if ({f_ack, d_ack} !== 2'b00) begin errors++; $display("FAIL rst_acks got %b want 00", {f_ack, d_ack}); end
    checks++; if ({f_rdata, d_rdata} !== 16'h0000) begin errors++; $display("FAIL rst_rdata got %h want 0000", {f_rdata, d_rdata}); end
    checks++; if ({z_busy, z_mem_clock, z_d_ack} !== 3'b000) begin errors++; $display("FAIL rst_z got %b want 000", {z_busy, z_mem_clock, z_d_ack}); end
  endtask

  task automatic test_fetch_read;
    f_req  = 1'b1;
    f_addr = 8'h10;
    for (int k = 0; k < 5; k++) begin
      tick;
      checks++; if (mem_clock !== (k == 0)) begin errors++; $display("FAIL fetch_mem_clock k=%0d got %h want %h", k, mem_clock, (k == 0)); end
      checks++; if (f_ack !== (k == 3)) begin errors++; $display("FAIL fetch_f_ack k=%0d got %h want %h", k, f_ack, (k == 3)); end
      checks++; if (d_ack !== 1'b0) begin errors++; $display("FAIL fetch_d_ack k=%0d got %h want 0", k, d_ack); end
      checks++; if (busy !== (k < 3)) begin errors++; $display("FAIL fetch_busy k=%0d got %h want %h", k, busy, (k < 3)); end
      if (k == 3) begin
        checks++; if (f_rdata !== 8'hA5) begin errors++; $display("FAIL fetch_rdata got %h want a5", f_rdata); end
        f_req = 1'b0;
      end
    end
  endtask

  task automatic test_store;
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_wdata = 8'h3C;
    for (int k = 0; k < 5; k++) begin
      tick;
      if (k == 0) begin
        d_addr = 8'h99; d_wdata = 8'hFF; d_we = 1'b0;
      end
      if (k < 3) begin
        checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL store_mem_write k=%0d got %h want 1", k, mem_write); end
        checks++; if (to_mem !== 8'h3C) begin errors++; $display("FAIL store_to_mem k=%0d got %h want 3c", k, to_mem); end
        checks++; if (address !== 8'h20) begin errors++; $display("FAIL store_address k=%0d got %h want 20", k, address); end
      end else begin
        checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL store_mw_after k=%0d got %h want 0", k, mem_write); end
      end
      checks++; if (d_ack !== (k == 3)) begin errors++; $display("FAIL store_d_ack k=%0d got %h want %h", k, d_ack, (k == 3)); end
      if (k == 3) d_req = 1'b0;
    end
    checks++; if (mem[8'h20] !== 8'h3C) begin errors++; $display("FAIL store_mem got %h want 3c", mem[8'h20]); end
    checks++; if (d_rdata !== 8'h00) begin errors++; $display("FAIL store_d_rdata got %h want 00", d_rdata); end
  endtask

  task automatic test_load_drop_req;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20;
    for (int k = 0; k < 5; k++) begin
      tick;
      if (k == 0) d_req = 1'b0;
      checks++; if (d_ack !== (k == 3)) begin errors++; $display("FAIL load_d_ack k=%0d got %h want %h", k, d_ack, (k == 3)); end
    end
    checks++; if (d_rdata !== 8'h3C) begin errors++; $display("FAIL load_d_rdata got %h want 3c", d_rdata); end
    checks++; if (f_rdata !== 8'hA5) begin errors++; $display("FAIL load_f_rdata_hold got %h want a5", f_rdata); end
  endtask

  task automatic test_contention;
    int   n = 0;
    int   last_t = 0;
    logic exp_d;
    reset = 1'b1; tick; reset = 1'b0;
    mem[8'h20] = 8'h3C;
    f_req = 1'b1; f_addr = 8'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20;
    for (int t = 0; t < 60 && n < 6; t++) begin
      tick;
      checks++; if (f_ack && d_ack) begin errors++; $display("FAIL contend_overlap t=%0d got 11 want not both", t); end
      if (f_ack || d_ack) begin
`ifdef ARB_ROUND_ROBIN_EN
        exp_d = (n % 2) == 1;
`else
        exp_d = 1'b1;
`endif
        checks++; if (d_ack !== exp_d) begin errors++; $display("FAIL contend_grant n=%0d got d=%h want d=%h", n, d_ack, exp_d); end
        if (d_ack) begin
          checks++; if (d_rdata !== 8'h3C) begin errors++; $display("FAIL contend_d_rdata got %h want 3c", d_rdata); end
        end else begin
          checks++; if (f_rdata !== 8'hA5) begin errors++; $display("FAIL contend_f_rdata got %h want a5", f_rdata); end
        end
        if (n > 0) begin
          checks++; if (t - last_t !== 5) begin errors++; $display("FAIL contend_spacing got %0d want 5", t - last_t); end
        end
        last_t = t;
        n++;
      end
    end
    checks++; if (n !== 6) begin errors++; $display("FAIL contend_timeout got %0d acks want 6", n); end
    f_req = 1'b0; d_req = 1'b0;
    tick; tick;
  endtask

  task automatic test_reset_mid;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h10;
    tick; tick;
    checks++; if (mem_clock !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL midrst_pre got mc=%h busy=%h want 0 1", mem_clock, busy); end
    reset = 1'b1; d_req = 1'b0;
    tick;
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %h want 0", busy); end
    checks++; if (mem_clock !== 1'b0) begin errors++; $display("FAIL midrst_mem_clock got %h want 0", mem_clock); end
    checks++; if (d_rdata !== 8'h00) begin errors++; $display("FAIL midrst_d_rdata got %h want 00", d_rdata); end
    for (int k = 0; k < 5; k++) begin
      tick;
      checks++; if (d_ack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_after k=%0d got ack=%h busy=%h want 0 0", k, d_ack, busy); end
    end
    checks++; if (d_rdata !== 8'h00) begin errors++; $display("FAIL midrst_d_rdata_end got %h want 00", d_rdata); end
  endtask

  task automatic test_wait0;
    z_d_req = 1'b1; z_d_we = 1'b0; z_d_addr = 8'h30;
    for (int k = 0; k < 4; k++) begin
      tick;
      if (k == 0) z_d_addr = 8'h31;
      if (k < 2) begin
        checks++; if (z_address !== 8'h30) begin errors++; $display("FAIL w0_address k=%0d got %h want 30", k, z_address); end
      end
      checks++; if (z_mem_clock !== (k == 0)) begin errors++; $display("FAIL w0_mem_clock k=%0d got %h want %h", k, z_mem_clock, (k == 0)); end
      checks++; if (z_d_ack !== (k == 2)) begin errors++; $display("FAIL w0_d_ack k=%0d got %h want %h", k, z_d_ack, (k == 2)); end
      if (k == 2) begin
        checks++; if (z_d_rdata !== 8'h7E) begin errors++; $display("FAIL w0_d_rdata got %h want 7e", z_d_rdata); end
        z_d_req = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset;
    test_fetch_read;
    test_store;
    test_load_drop_req;
    test_contention;
    test_reset_mid;
    test_wait0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: WAIT_CYCLES, default 1, number of idle cycles between the memory strobe and data capture (0..15).
REQ-002 Ports SHALL be, in order:
- clock  in  1  sole clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- f_req  in  1  instruction-fetch read request
- f_addr  in  8  fetch address
- f_ack  out  1  fetch done, one-cycle pulse
- f_rdata  out  8  fetch read data
- d_req  in  1  data load/store request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  8  data address
- d_wdata  in  8  store data
- d_ack  out  1  data done, one-cycle pulse
- d_rdata  out  8  load read data
- address  out  8  memory address
- to_mem  out  8  memory write data
- from_mem  in  8  memory read data
- mem_clock  out  1  memory strobe; memory acts on its rising edge
- mem_write  out  1  memory write enable
- busy  out  1  high when state is not IDLE
REQ-003 Every output SHALL be driven from a register.

Function
REQ-004 The FSM SHALL have states IDLE, STROBE, WAIT and DONE.
REQ-005 IDLE: if a request is pending and neither ack is high, the arbiter SHALL grant one port, latch its address, write data and write flag, drive address/to_mem/mem_write, and go to STROBE.
- This grant edge is edge G.
REQ-006 Grant rule: a fetch is a read; mem_write=d_we for a data grant and 0 for a fetch grant.
REQ-007 STROBE SHALL last one cycle with mem_clock=1, then go to WAIT, or to DONE when WAIT_CYCLES=0.
REQ-008 WAIT SHALL hold mem_clock=0 for exactly WAIT_CYCLES cycles using a 4-bit down-counter, then go to DONE.
REQ-009 On the DONE->IDLE edge (G+2+WAIT_CYCLES):
- the granted port's ack SHALL be 1 for exactly one cycle;
- for a read, from_mem SHALL be captured into that port's rdata;
- mem_write SHALL clear to 0.
REQ-010 A store SHALL leave d_rdata unchanged.
REQ-011 rdata SHALL hold its value until the next read completion on the same port.
REQ-012 address, to_mem and mem_write SHALL remain stable from G through DONE.
REQ-013 Request inputs that change after G SHALL be ignored.
REQ-014 A request deasserted after G SHALL still complete and be acked.
REQ-015 Requesters drop req on the edge where ack is sampled; IDLE SHALL NOT grant in the cycle an ack is high.
- Back-to-back grants are therefore spaced at least one idle cycle apart.
REQ-016 Each port SHALL have at most one outstanding transaction, and f_ack and d_ack SHALL never be high together.
REQ-017 Throughput SHALL be one transaction per WAIT_CYCLES+4 cycles under continuous request.

Reset
REQ-018 reset SHALL take effect at the next posedge and override all other activity.
REQ-019 Reset values SHALL be:
- state = IDLE, busy = 0;
- mem_clock = 0, mem_write = 0;
- address = 0, to_mem = 0;
- f_ack = d_ack = 0, f_rdata = d_rdata = 0;
- wait counter = 0, round-robin pointer per REQ-022.
REQ-020 A reset during STROBE, WAIT or DONE SHALL abandon the transaction with no ack issued.

Configuration
REQ-021 Without macro ARB_ROUND_ROBIN_EN, simultaneous requests SHALL grant the data port (fixed priority: load/store over fetch).
REQ-022 With ARB_ROUND_ROBIN_EN defined:
- a tie SHALL grant the port not granted last;
- a one-bit last-grant pointer SHALL update on every grant;
- reset sets the pointer to "data", so the first tie after reset goes to fetch.
- A lone request SHALL be granted immediately in both builds.

Verification
REQ-023 Fetch read, WAIT_CYCLES=1, memory[0x10]=0xA5, f_req at G:
- mem_clock high at G+1 only;
- f_ack at G+3 with f_rdata=0xA5;
- d_ack stays 0.
REQ-024 Data store, d_addr=0x20, d_wdata=0x3C, d_we=1:
- mem_write=1 and to_mem=0x3C from G through DONE;
- memory[0x20]=0x3C afterwards;
- d_ack pulses, d_rdata unchanged, mem_write=0 after ack.
REQ-025 f_req and d_req rise together, held high, 6 transactions:
- default build grants D,D,D...;
- ARB_ROUND_ROBIN_EN build grants F,D,F,D,F,D;
- no ack ever overlaps.
REQ-026 Reset asserted during WAIT of a load:
- next cycle busy=0 and mem_clock=0;
- d_ack never pulses, d_rdata=0.
REQ-027 WAIT_CYCLES=0, load of 0x7E: d_ack at G+2 with d_rdata=0x7E; d_addr changed at G+1 has no effect.
